// File: rtl/arm_pkg.sv
// Shared types for the ARM core pipeline control blocks.
package arm_pkg;

   // Operand source selected for an Execute-stage ALU input.
   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,  // register file value read in Decode
      FWD_WB  = 2'b01,  // ResultW from the Writeback stage
      FWD_MEM = 2'b10   // ALUOutM from the Memory stage
   } fwd_sel_t;

   // Data-memory access sequencer states.
   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_t;

   // Pick the youngest in-flight producer of source register ra.
   // Memory stage is younger than Writeback, so it wins on a double match.
   function automatic fwd_sel_t fwd_select(
      input logic [3:0] ra,
      input logic [3:0] wa3m,
      input logic       reg_write_m,
      input logic [3:0] wa3w,
      input logic       reg_write_w
   );
      if (reg_write_m && (wa3m == ra)) begin
         return FWD_MEM;
      end else if (reg_write_w && (wa3w == ra)) begin
         return FWD_WB;
      end else begin
         return FWD_RF;
      end
   endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Wait-state sequencer for multi-cycle data-memory accesses with a timeout.
// Handshake: an access is requested by mem_req while the Memory stage holds a
// memory instruction; it completes in any cycle where mem_ready is high. The
// request is sampled only in IDLE; while in WAIT only mem_ready matters.
module mem_wait_fsm
   import arm_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic mem_req,
   input  logic mem_ready,
   output logic mem_stall,
   output logic mem_err
);

   localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(MEM_TIMEOUT - 1);

   mem_state_t    state;
   mem_state_t    next_state;
   logic [TW-1:0] timer;
   logic          at_limit;

   // Next state, stall request and timeout pulse from the current state.
   always_comb begin
      next_state = state;
      at_limit   = (timer == T_LAST);
      mem_stall  = 1'b0;
      mem_err    = 1'b0;
      case (state)
         IDLE: begin
            // A zero-wait access (ready with the request) never leaves IDLE.
            if (mem_req && !mem_ready) begin
               next_state = WAIT;
               mem_stall  = 1'b1;
            end
         end
         WAIT: begin
            if (mem_ready) begin
               next_state = IDLE;
            end else if (at_limit) begin
               // Abandon the access: release the pipeline and flag the error.
               next_state = IDLE;
               mem_err    = 1'b1;
            end else begin
               mem_stall  = 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // State register and wait timer; timer restarts at 0 on every entry to WAIT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         timer <= '0;
      end else begin
         state <= next_state;
         if ((state == WAIT) && (next_state == WAIT)) begin
            timer <= timer + TW'(1);
         end else begin
            timer <= '0;
         end
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage ARM core: operand forwarding,
// load-use and branch stall/flush, memory wait-state stalls and a stall counter.
module hazard_ctrl
   import arm_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       RA1D,
   input  logic [3:0]       RA2D,
   input  logic [3:0]       RA1E,
   input  logic [3:0]       RA2E,
   input  logic [3:0]       WA3E,
   input  logic [3:0]       WA3M,
   input  logic [3:0]       WA3W,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             MemtoRegE,
   input  logic             PCWrPendingF,
   input  logic             PCSrcW,
   input  logic             BranchTakenE,
   input  logic             mem_req_M,
   input  logic             mem_ready,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cycles
);

   fwd_sel_t fwd_a;
   fwd_sel_t fwd_b;
   logic     ldr_stall;
   logic     mem_stall;

   mem_wait_fsm #(
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) u_mem_wait (
      .clk      (clk),
      .reset    (reset),
      .mem_req  (mem_req_M),
      .mem_ready(mem_ready),
      .mem_stall(mem_stall),
      .mem_err  (mem_err)
   );

   // Forwarding selects for both Execute-stage operands.
   always_comb begin
      fwd_a     = fwd_select(RA1E, WA3M, RegWriteM, WA3W, RegWriteW);
      fwd_b     = fwd_select(RA2E, WA3M, RegWriteM, WA3W, RegWriteW);
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
   end

   // Stall/flush generation; a memory wait freezes F..M and overrides everything.
   always_comb begin
      ldr_stall = MemtoRegE && ((WA3E == RA1D) || (WA3E == RA2D));
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      FlushW    = 1'b0;
      if (mem_stall) begin
         // Frozen stages re-evaluate branch and load-use hazards after release,
         // so no flush is issued into them while they are held.
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         FlushW = 1'b1;
      end else begin
         StallF = ldr_stall || PCWrPendingF;
         StallD = ldr_stall;
         FlushD = PCWrPendingF || PCSrcW || BranchTakenE;
         FlushE = ldr_stall || BranchTakenE;
      end
   end

   // Saturating count of fetch-stall cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles <= '0;
      end else if (StallF && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus a randomized run against a
// cycle-level reference model. A second instance with a 4-bit counter shares
// all inputs to exercise counter saturation.
module tb_hazard_ctrl;

   localparam int MT       = 16;
   localparam int CNT_MAX  = 65535;
   localparam int CNT4_MAX = 15;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [3:0]  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
   logic        RegWriteM, RegWriteW, MemtoRegE, PCWrPendingF, PCSrcW;
   logic        BranchTakenE, mem_req_M, mem_ready;

   logic [1:0]  ForwardAE, ForwardBE;
   logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;
   logic [15:0] stall_cycles;

   logic [1:0]  ForwardAE4, ForwardBE4;
   logic        StallF4, StallD4, StallE4, StallM4, FlushD4, FlushE4, FlushW4, mem_err4;
   logic [3:0]  stall_cycles4;

   hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
      .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
      .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
      .PCWrPendingF(PCWrPendingF), .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE),
      .mem_req_M(mem_req_M), .mem_ready(mem_ready),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
      .mem_err(mem_err), .stall_cycles(stall_cycles)
   );

   hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(4)) dut4 (
      .clk(clk), .reset(reset),
      .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
      .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
      .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
      .PCWrPendingF(PCWrPendingF), .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE),
      .mem_req_M(mem_req_M), .mem_ready(mem_ready),
      .ForwardAE(ForwardAE4), .ForwardBE(ForwardBE4),
      .StallF(StallF4), .StallD(StallD4), .StallE(StallE4), .StallM(StallM4),
      .FlushD(FlushD4), .FlushE(FlushE4), .FlushW(FlushW4),
      .mem_err(mem_err4), .stall_cycles(stall_cycles4)
   );

   int tests = 0;
   int fails = 0;

   // ---------------- reference model ----------------
   // wait_age: -1 when no access is outstanding, otherwise the number of
   // cycles the current access has already been waiting (>= 1).
   int wait_age = -1;
   int exp_cnt  = 0;
   int exp_cnt4 = 0;

   // Output vector layout: {FwdA[1:0], FwdB[1:0], SF, SD, SE, SM, FD, FE, FW, err}
   function automatic logic [11:0] obs_main();
      return {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
              FlushD, FlushE, FlushW, mem_err};
   endfunction

   function automatic logic [11:0] obs_4();
      return {ForwardAE4, ForwardBE4, StallF4, StallD4, StallE4, StallM4,
              FlushD4, FlushE4, FlushW4, mem_err4};
   endfunction

   function automatic logic [1:0] ref_fwd(input logic [3:0] ra);
      if (RegWriteM && WA3M == ra) return 2'b10;
      if (RegWriteW && WA3W == ra) return 2'b01;
      return 2'b00;
   endfunction

   // Age of the access seen this cycle: 0 for a fresh access that must wait.
   function automatic int cur_age();
      if (wait_age >= 0) return wait_age;
      if (mem_req_M && !mem_ready) return 0;
      return -1;
   endfunction

   function automatic logic [11:0] ref_outputs();
      int   age;
      logic ldr, mst, merr;
      logic sf, sd, se, sm, fd, fe, fw;
      age  = cur_age();
      mst  = (age >= 0) && !mem_ready && (age < MT);
      merr = (age == MT) && !mem_ready;
      ldr  = MemtoRegE && (WA3E == RA1D || WA3E == RA2D);
      if (mst) begin
         {sf, sd, se, sm, fd, fe, fw} = 7'b1111001;
      end else begin
         sf = ldr | PCWrPendingF;
         sd = ldr;
         se = 1'b0;
         sm = 1'b0;
         fd = PCWrPendingF | PCSrcW | BranchTakenE;
         fe = ldr | BranchTakenE;
         fw = 1'b0;
      end
      return {ref_fwd(RA1E), ref_fwd(RA2E), sf, sd, se, sm, fd, fe, fw, merr};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic clear_inputs();
      {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
      {RegWriteM, RegWriteW, MemtoRegE, PCWrPendingF, PCSrcW} = '0;
      {BranchTakenE, mem_req_M, mem_ready} = '0;
   endtask

   // Advance one clock; the model commits at the same edge as the DUT.
   task automatic tick();
      logic [11:0] v;
      int          age;
      v   = ref_outputs();
      age = cur_age();
      @(posedge clk);
      if (reset) begin
         wait_age = -1;
         exp_cnt  = 0;
         exp_cnt4 = 0;
      end else begin
         if (v[7]) begin
            if (exp_cnt < CNT_MAX) exp_cnt++;
            if (exp_cnt4 < CNT4_MAX) exp_cnt4++;
         end
         if (age < 0 || mem_ready || age == MT) wait_age = -1;
         else wait_age = age + 1;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      clear_inputs();
      reset    = 1'b1;
      wait_age = -1;
      exp_cnt  = 0;
      exp_cnt4 = 0;
      tick();
      reset = 1'b0;
   endtask

   // ---------------- test tasks ----------------
   task automatic test_reset();
      clear_inputs();
      reset = 1'b1;
      #1;
      tests++;
      if (stall_cycles !== 16'd0) begin
         fails++; $display("FAIL reset_cnt: got %0d want 0", stall_cycles);
      end
      tests++;
      if (obs_main() !== 12'b0) begin
         fails++; $display("FAIL reset_outs: got %b want %b", obs_main(), 12'b0);
      end
      // Combinational paths keep following inputs while reset is held.
      RegWriteM = 1'b1; WA3M = 4'd9; RA1E = 4'd9;
      #1;
      tests++;
      if (ForwardAE !== 2'b10) begin
         fails++; $display("FAIL reset_fwd: got %b want 10", ForwardAE);
      end
      tick();
      reset = 1'b0;
   endtask

   task automatic test_forwarding();
      do_reset();
      RegWriteM = 1; WA3M = 3; RegWriteW = 1; WA3W = 3; RA1E = 3; RA2E = 7;
      #1;
      tests++;
      if (obs_main() !== 12'b1000_0000_0000) begin
         fails++; $display("FAIL fwd_m_wins: got %b want %b", obs_main(), 12'b1000_0000_0000);
      end
      RegWriteM = 0;
      #1;
      tests++;
      if (obs_main() !== 12'b0100_0000_0000) begin
         fails++; $display("FAIL fwd_w: got %b want %b", obs_main(), 12'b0100_0000_0000);
      end
      RegWriteM = 1; WA3M = 7; RegWriteW = 0;
      #1;
      tests++;
      if (obs_main() !== 12'b0010_0000_0000) begin
         fails++; $display("FAIL fwd_b_m: got %b want %b", obs_main(), 12'b0010_0000_0000);
      end
      tick();
   endtask

   task automatic test_load_use();
      do_reset();
      MemtoRegE = 1; WA3E = 5; RA2D = 5; RA1D = 1;
      #1;
      tests++;
      if (obs_main() !== 12'b0000_1100_0100) begin
         fails++; $display("FAIL ldr_stall: got %b want %b", obs_main(), 12'b0000_1100_0100);
      end
      tick();
      clear_inputs();
      #1;
      tests++;
      if (obs_main() !== 12'b0) begin
         fails++; $display("FAIL ldr_release: got %b want %b", obs_main(), 12'b0);
      end
      tests++;
      if (stall_cycles !== 16'd1) begin
         fails++; $display("FAIL ldr_cnt: got %0d want 1", stall_cycles);
      end
   endtask

   task automatic test_branch();
      do_reset();
      BranchTakenE = 1; PCWrPendingF = 1;
      #1;
      tests++;
      if (obs_main() !== 12'b0000_1000_1100) begin
         fails++; $display("FAIL branch: got %b want %b", obs_main(), 12'b0000_1000_1100);
      end
      clear_inputs(); PCSrcW = 1;
      #1;
      tests++;
      if (obs_main() !== 12'b0000_0000_1000) begin
         fails++; $display("FAIL pcsrcw: got %b want %b", obs_main(), 12'b0000_0000_1000);
      end
      tick();
   endtask

   task automatic test_mem_wait();
      do_reset();
      mem_req_M = 1; mem_ready = 0; BranchTakenE = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         tests++;
         if (obs_main() !== 12'b0000_1111_0010) begin
            fails++; $display("FAIL mem_wait_c%0d: got %b want %b", i, obs_main(), 12'b0000_1111_0010);
         end
         tick();
      end
      mem_ready = 1;
      #1;
      tests++;
      if (obs_main() !== 12'b0000_0000_1100) begin
         fails++; $display("FAIL mem_ready_rel: got %b want %b", obs_main(), 12'b0000_0000_1100);
      end
      tick();
      clear_inputs();
      #1;
      tests++;
      if (stall_cycles !== 16'd3) begin
         fails++; $display("FAIL mem_wait_cnt: got %0d want 3", stall_cycles);
      end
      tests++;
      if (obs_main() !== 12'b0) begin
         fails++; $display("FAIL mem_idle_after: got %b want %b", obs_main(), 12'b0);
      end
      // Zero-wait access: no stall, and nothing is left pending.
      mem_req_M = 1; mem_ready = 1;
      #1;
      tests++;
      if (StallF !== 1'b0) begin
         fails++; $display("FAIL zero_wait: got StallF=%b want 0", StallF);
      end
      tick();
      clear_inputs();
      #1;
      tests++;
      if (obs_main() !== 12'b0) begin
         fails++; $display("FAIL zero_wait_after: got %b want %b", obs_main(), 12'b0);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      for (int round = 0; round < 2; round++) begin
         mem_req_M = 1; mem_ready = 0;
         for (int i = 0; i < MT; i++) begin
            #1;
            tests++;
            if (obs_main() !== 12'b0000_1111_0010) begin
               fails++; $display("FAIL tmo_stall_r%0d_c%0d: got %b want %b", round, i, obs_main(), 12'b0000_1111_0010);
            end
            tick();
         end
         // Limit cycle: abandon with mem_err, unless ready arrives right now.
         mem_ready = (round == 1);
         #1;
         tests++;
         if (obs_main() !== ((round == 0) ? 12'b1 : 12'b0)) begin
            fails++; $display("FAIL tmo_limit_r%0d: got %b want %b", round, obs_main(), (round == 0) ? 12'b1 : 12'b0);
         end
         tick();
         clear_inputs();
         #1;
         tests++;
         if (obs_main() !== 12'b0) begin
            fails++; $display("FAIL tmo_after_r%0d: got %b want %b", round, obs_main(), 12'b0);
         end
         tests++;
         if (stall_cycles !== 16'(MT * (round + 1))) begin
            fails++; $display("FAIL tmo_cnt_r%0d: got %0d want %0d", round, stall_cycles, MT * (round + 1));
         end
         tests++;
         if (stall_cycles4 !== 4'd15) begin
            fails++; $display("FAIL cnt4_sat_r%0d: got %0d want 15", round, stall_cycles4);
         end
      end
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      mem_req_M = 1; mem_ready = 0;
      for (int i = 0; i < 4; i++) tick();
      reset = 1'b1; mem_req_M = 0;
      wait_age = -1; exp_cnt = 0; exp_cnt4 = 0;
      #1;
      tests++;
      if (obs_main() !== 12'b0) begin
         fails++; $display("FAIL rst_wait_outs: got %b want %b", obs_main(), 12'b0);
      end
      tests++;
      if (stall_cycles !== 16'd0 || stall_cycles4 !== 4'd0) begin
         fails++; $display("FAIL rst_wait_cnt: got %0d/%0d want 0/0", stall_cycles, stall_cycles4);
      end
      tick();
      reset = 1'b0;
      #1;
      tests++;
      if (obs_main() !== 12'b0) begin
         fails++; $display("FAIL rst_wait_idle: got %b want %b", obs_main(), 12'b0);
      end
      tick();
      mem_req_M = 1;
      #1;
      tests++;
      if (obs_main() !== 12'b0000_1111_0010) begin
         fails++; $display("FAIL rst_new_access: got %b want %b", obs_main(), 12'b0000_1111_0010);
      end
      tick();
      mem_ready = 1;
      tick();
      clear_inputs();
   endtask

   task automatic test_random();
      logic [11:0] exp_v;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         RA1D = 4'($urandom_range(0, 3)); RA2D = 4'($urandom_range(0, 3));
         RA1E = 4'($urandom_range(0, 3)); RA2E = 4'($urandom_range(0, 3));
         WA3E = 4'($urandom_range(0, 3)); WA3M = 4'($urandom_range(0, 3));
         WA3W = 4'($urandom_range(0, 3));
         RegWriteM    = 1'($urandom_range(0, 1));
         RegWriteW    = 1'($urandom_range(0, 1));
         MemtoRegE    = ($urandom_range(0, 3) == 0);
         PCWrPendingF = ($urandom_range(0, 3) == 0);
         PCSrcW       = ($urandom_range(0, 5) == 0);
         BranchTakenE = ($urandom_range(0, 4) == 0);
         mem_req_M    = ($urandom_range(0, 3) == 0);
         mem_ready    = ($urandom_range(0, 5) == 0);
         #1;
         exp_v = ref_outputs();
         tests++;
         if (obs_main() !== exp_v) begin
            fails++; $display("FAIL rand_outs_c%0d: got %b want %b", c, obs_main(), exp_v);
         end
         tests++;
         if (obs_4() !== exp_v) begin
            fails++; $display("FAIL rand_outs4_c%0d: got %b want %b", c, obs_4(), exp_v);
         end
         tests++;
         if (stall_cycles !== 16'(exp_cnt) || stall_cycles4 !== 4'(exp_cnt4)) begin
            fails++; $display("FAIL rand_cnt_c%0d: got %0d/%0d want %0d/%0d", c, stall_cycles, stall_cycles4, exp_cnt, exp_cnt4);
         end
         tick();
      end
      clear_inputs();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      clear_inputs();
      reset = 1'b1;
      @(negedge clk);
      test_reset();
      test_forwarding();
      test_load_use();
      test_branch();
      test_mem_wait();
      test_timeout();
      test_reset_mid_wait();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
